// File: rtl/compare_stats_if.sv
`default_nettype none
// ============================================================================
//  Module      : compare_stats_if
//  Description : Bundles the sample inputs, the window control and the
//                result handshake of compare_stats.
//                master : drives start, sample_en, flags, out_ready;
//                         observes busy, counts, out_valid.
//                slave  : the compare_stats side (mirror of master).
//  Ports       : none (signal bundle only); CNT_W sets count width.
//  Revision    : 1.0 - initial release
// ============================================================================
interface compare_stats_if #(
    parameter int CNT_W = 8
) ();
    logic             start;
    logic             sample_en;
    logic             A_gt_B_reg;
    logic             A_eq_B_reg;
    logic             A_lt_B_reg;
    logic             busy;
    logic [CNT_W-1:0] gt_count;
    logic [CNT_W-1:0] eq_count;
    logic [CNT_W-1:0] lt_count;
    logic [CNT_W-1:0] err_count;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output start, sample_en, A_gt_B_reg, A_eq_B_reg, A_lt_B_reg, out_ready,
        input  busy, gt_count, eq_count, lt_count, err_count, out_valid
    );

    modport slave (
        input  start, sample_en, A_gt_B_reg, A_eq_B_reg, A_lt_B_reg, out_ready,
        output busy, gt_count, eq_count, lt_count, err_count, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/compare_stats.sv
`default_nettype none
// ============================================================================
//  Module      : compare_stats
//  Description : Counts the outcomes of a registered magnitude comparator
//                over a window of WINDOW qualified samples. One-hot flag sets
//                {gt,eq,lt} increment their own count; any other pattern
//                (including the post-reset 000) increments err_count. At the
//                end of the window the four counts are held with out_valid
//                until out_ready accepts them.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active low
//                bus  - compare_stats_if.slave: start, sample_en, flags,
//                       out_ready in; busy, four counts, out_valid out
//  Parameters  : WINDOW (1..255) samples per window, CNT_W count width
//  Revision    : 1.0 - initial release
// ============================================================================
module compare_stats #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    compare_stats_if.slave   bus
);

    // Sample counter is just wide enough to reach WINDOW itself.
    localparam int                c_SCNT_W = $clog2(WINDOW + 1);
    localparam logic [c_SCNT_W-1:0] c_LAST = c_SCNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  c_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_SCNT_W-1:0] r_scnt;
    logic [CNT_W-1:0]    r_gt;
    logic [CNT_W-1:0]    r_eq;
    logic [CNT_W-1:0]    r_lt;
    logic [CNT_W-1:0]    r_err;
    logic                r_busy;
    logic                r_valid;

    logic [2:0]          w_flags;

    assign w_flags = {bus.A_gt_B_reg, bus.A_eq_B_reg, bus.A_lt_B_reg};

    // Saturating increment: a full count sticks at its maximum.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_scnt  <= '0;
            r_gt    <= '0;
            r_eq    <= '0;
            r_lt    <= '0;
            r_err   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Counts from the last window stay visible until start.
                    if (bus.start) begin
                        r_scnt  <= '0;
                        r_gt    <= '0;
                        r_eq    <= '0;
                        r_lt    <= '0;
                        r_err   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ACCUM;
                    end
                end

                S_ACCUM: begin
                    if (bus.sample_en) begin
                        r_scnt <= r_scnt + 1'b1;
                        case (w_flags)
                            3'b100:  r_gt  <= sat_inc(r_gt);
                            3'b010:  r_eq  <= sat_inc(r_eq);
                            3'b001:  r_lt  <= sat_inc(r_lt);
                            default: r_err <= sat_inc(r_err);
                        endcase
                        // This edge accepts sample number WINDOW.
                        if (r_scnt == c_LAST) begin
                            r_valid <= 1'b1;
                            r_state <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    // start is deliberately not looked at here.
                    if (r_valid && bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.out_valid = r_valid;
    assign bus.gt_count  = r_gt;
    assign bus.eq_count  = r_eq;
    assign bus.lt_count  = r_lt;
    assign bus.err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_compare_stats.sv
`default_nettype none
// ============================================================================
//  Module      : tb_compare_stats
//  Description : Directed bench for compare_stats. Two instances: the
//                default 16-sample / 8-bit build and a 20-sample / 4-bit
//                build for saturation. Inputs change on the falling edge,
//                outputs are observed on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_compare_stats;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    compare_stats_if #(.CNT_W(8)) u_if ();
    compare_stats_if #(.CNT_W(4)) u_if_sat ();

    compare_stats #(.WINDOW(16), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    compare_stats #(.WINDOW(20), .CNT_W(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (u_if_sat.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_flags(input logic [2:0] f);
        {u_if.A_gt_B_reg, u_if.A_eq_B_reg, u_if.A_lt_B_reg} = f;
    endtask

    task automatic idle_inputs();
        u_if.start = 1'b0;
        u_if.sample_en = 1'b0;
        u_if.out_ready = 1'b0;
        set_flags(3'b000);
        u_if_sat.start = 1'b0;
        u_if_sat.sample_en = 1'b0;
        u_if_sat.out_ready = 1'b0;
        {u_if_sat.A_gt_B_reg, u_if_sat.A_eq_B_reg, u_if_sat.A_lt_B_reg} = 3'b000;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        u_if.start = 1'b1;
        u_if.sample_en = 1'b1;
        u_if_sat.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_flags(3'(i + 1));
            @(negedge clk);
        end
        checks++;
        if ({u_if.busy, u_if.out_valid} !== 2'b00) begin
            failures++;
            $display("FAIL reset_status: got %b expected 00", {u_if.busy, u_if.out_valid});
        end
        checks++;
        if ({u_if.gt_count, u_if.eq_count, u_if.lt_count, u_if.err_count} !== 32'h0) begin
            failures++;
            $display("FAIL reset_counts: got %h expected 00000000",
                     {u_if.gt_count, u_if.eq_count, u_if.lt_count, u_if.err_count});
        end
        checks++;
        if ({u_if_sat.busy, u_if_sat.out_valid, u_if_sat.gt_count} !== 6'b0) begin
            failures++;
            $display("FAIL reset_sat: got %b expected 000000",
                     {u_if_sat.busy, u_if_sat.out_valid, u_if_sat.gt_count});
        end
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        logic [2:0] f;
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        checks++;
        if ({u_if.busy, u_if.out_valid, u_if.gt_count, u_if.eq_count, u_if.lt_count,
             u_if.err_count} !== {2'b10, 32'h0}) begin
            failures++;
            $display("FAIL nominal_start: busy=%b valid=%b counts=%h expected busy=1 valid=0 counts=0",
                     u_if.busy, u_if.out_valid,
                     {u_if.gt_count, u_if.eq_count, u_if.lt_count, u_if.err_count});
        end
        u_if.sample_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            f = (i < 6) ? 3'b100 : (i < 11) ? 3'b010 : (i < 15) ? 3'b001 : 3'b000;
            set_flags(f);
            @(negedge clk);
            if (i == 14) begin
                checks++;
                if (u_if.out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL nominal_early_valid: got %b expected 0", u_if.out_valid);
                end
            end
        end
        u_if.sample_en = 1'b0;
        checks++;
        if ({u_if.busy, u_if.out_valid} !== 2'b11) begin
            failures++;
            $display("FAIL nominal_close: got %b expected 11", {u_if.busy, u_if.out_valid});
        end
        checks++;
        if ({u_if.gt_count, u_if.eq_count, u_if.lt_count, u_if.err_count} !== 32'h06050401) begin
            failures++;
            $display("FAIL nominal_counts: got %h expected 06050401",
                     {u_if.gt_count, u_if.eq_count, u_if.lt_count, u_if.err_count});
        end
        u_if.out_ready = 1'b1;
        @(negedge clk);
        u_if.out_ready = 1'b0;
        u_if.sample_en = 1'b1;
        set_flags(3'b100);
        checks++;
        if ({u_if.busy, u_if.out_valid} !== 2'b00) begin
            failures++;
            $display("FAIL nominal_accept: got %b expected 00", {u_if.busy, u_if.out_valid});
        end
        @(negedge clk);
        u_if.sample_en = 1'b0;
        checks++;
        if ({u_if.gt_count, u_if.eq_count, u_if.lt_count, u_if.err_count} !== 32'h06050401) begin
            failures++;
            $display("FAIL nominal_held: got %h expected 06050401",
                     {u_if.gt_count, u_if.eq_count, u_if.lt_count, u_if.err_count});
        end
    endtask

    // Leaves the DUT in HOLD for test_backpressure.
    task automatic test_gaps();
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            u_if.sample_en = (i % 2 == 0);
            if (i % 2 == 1)      set_flags(3'b100);
            else if (i % 4 == 0) set_flags(3'b110);
            else                 set_flags(3'b111);
            @(negedge clk);
            if (i == 29) begin
                checks++;
                if ({u_if.out_valid, u_if.gt_count, u_if.eq_count, u_if.lt_count,
                     u_if.err_count} !== {1'b0, 32'h0000000F}) begin
                    failures++;
                    $display("FAIL gaps_partial: valid=%b counts=%h expected valid=0 counts=0000000f",
                             u_if.out_valid,
                             {u_if.gt_count, u_if.eq_count, u_if.lt_count, u_if.err_count});
                end
            end
        end
        u_if.sample_en = 1'b0;
        checks++;
        if ({u_if.busy, u_if.out_valid} !== 2'b11) begin
            failures++;
            $display("FAIL gaps_close: got %b expected 11", {u_if.busy, u_if.out_valid});
        end
        checks++;
        if ({u_if.gt_count, u_if.eq_count, u_if.lt_count, u_if.err_count} !== 32'h00000010) begin
            failures++;
            $display("FAIL gaps_counts: got %h expected 00000010",
                     {u_if.gt_count, u_if.eq_count, u_if.lt_count, u_if.err_count});
        end
    endtask

    task automatic test_backpressure();
        u_if.out_ready = 1'b0;
        u_if.sample_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            u_if.start = i[0];
            set_flags(3'(i));
            @(negedge clk);
            checks++;
            if ({u_if.busy, u_if.out_valid, u_if.gt_count, u_if.eq_count, u_if.lt_count,
                 u_if.err_count} !== {2'b11, 32'h00000010}) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: busy=%b valid=%b counts=%h expected 1 1 00000010",
                         i, u_if.busy, u_if.out_valid,
                         {u_if.gt_count, u_if.eq_count, u_if.lt_count, u_if.err_count});
            end
        end
        // start together with out_ready: only the handshake is taken.
        u_if.start = 1'b1;
        u_if.out_ready = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        u_if.out_ready = 1'b0;
        checks++;
        if ({u_if.busy, u_if.out_valid} !== 2'b00) begin
            failures++;
            $display("FAIL backpressure_accept: got %b expected 00", {u_if.busy, u_if.out_valid});
        end
        @(negedge clk);
        u_if.sample_en = 1'b0;
        checks++;
        if ({u_if.busy, u_if.gt_count, u_if.eq_count, u_if.lt_count,
             u_if.err_count} !== {1'b0, 32'h00000010}) begin
            failures++;
            $display("FAIL backpressure_no_restart: busy=%b counts=%h expected 0 00000010",
                     u_if.busy, {u_if.gt_count, u_if.eq_count, u_if.lt_count, u_if.err_count});
        end
    endtask

    task automatic test_saturation();
        u_if_sat.start = 1'b1;
        @(negedge clk);
        u_if_sat.start = 1'b0;
        u_if_sat.sample_en = 1'b1;
        {u_if_sat.A_gt_B_reg, u_if_sat.A_eq_B_reg, u_if_sat.A_lt_B_reg} = 3'b100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 18) begin
                checks++;
                if ({u_if_sat.out_valid, u_if_sat.gt_count} !== 5'b0_1111) begin
                    failures++;
                    $display("FAIL sat_before_close: valid=%b gt=%0d expected valid=0 gt=15",
                             u_if_sat.out_valid, u_if_sat.gt_count);
                end
            end
        end
        u_if_sat.sample_en = 1'b0;
        checks++;
        if ({u_if_sat.busy, u_if_sat.out_valid} !== 2'b11) begin
            failures++;
            $display("FAIL sat_close: got %b expected 11", {u_if_sat.busy, u_if_sat.out_valid});
        end
        checks++;
        if ({u_if_sat.gt_count, u_if_sat.eq_count, u_if_sat.lt_count,
             u_if_sat.err_count} !== 16'hF000) begin
            failures++;
            $display("FAIL sat_counts: got %h expected f000",
                     {u_if_sat.gt_count, u_if_sat.eq_count, u_if_sat.lt_count, u_if_sat.err_count});
        end
        u_if_sat.out_ready = 1'b1;
        @(negedge clk);
        u_if_sat.out_ready = 1'b0;
    endtask

    task automatic test_midreset();
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        u_if.sample_en = 1'b1;
        set_flags(3'b010);
        repeat (7) @(negedge clk);
        checks++;
        if ({u_if.busy, u_if.eq_count} !== {1'b1, 8'd7}) begin
            failures++;
            $display("FAIL midreset_partial: busy=%b eq=%0d expected busy=1 eq=7",
                     u_if.busy, u_if.eq_count);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if ({u_if.busy, u_if.out_valid, u_if.gt_count, u_if.eq_count, u_if.lt_count,
             u_if.err_count} !== {2'b00, 32'h0}) begin
            failures++;
            $display("FAIL midreset_cleared: busy=%b valid=%b counts=%h expected 0 0 00000000",
                     u_if.busy, u_if.out_valid,
                     {u_if.gt_count, u_if.eq_count, u_if.lt_count, u_if.err_count});
        end
        @(negedge clk);
        checks++;
        if ({u_if.busy, u_if.eq_count} !== 9'h0) begin
            failures++;
            $display("FAIL midreset_stays_idle: busy=%b eq=%0d expected 0 0", u_if.busy, u_if.eq_count);
        end
        u_if.sample_en = 1'b0;
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        u_if.sample_en = 1'b1;
        set_flags(3'b001);
        repeat (16) @(negedge clk);
        u_if.sample_en = 1'b0;
        checks++;
        if ({u_if.out_valid, u_if.gt_count, u_if.eq_count, u_if.lt_count,
             u_if.err_count} !== {1'b1, 32'h00001000}) begin
            failures++;
            $display("FAIL midreset_fresh_window: valid=%b counts=%h expected 1 00001000",
                     u_if.out_valid, {u_if.gt_count, u_if.eq_count, u_if.lt_count, u_if.err_count});
        end
    endtask

    // Handshake at edge h, start at h+1: earliest legal restart.
    task automatic test_back_to_back();
        u_if.out_ready = 1'b1;
        @(negedge clk);
        u_if.out_ready = 1'b0;
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        checks++;
        if ({u_if.busy, u_if.out_valid, u_if.lt_count} !== {2'b10, 8'd0}) begin
            failures++;
            $display("FAIL back_to_back_restart: busy=%b valid=%b lt=%0d expected 1 0 0",
                     u_if.busy, u_if.out_valid, u_if.lt_count);
        end
        u_if.sample_en = 1'b1;
        set_flags(3'b100);
        @(negedge clk);
        u_if.sample_en = 1'b0;
        checks++;
        if (u_if.gt_count !== 8'd1) begin
            failures++;
            $display("FAIL back_to_back_first_sample: got %0d expected 1", u_if.gt_count);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_nominal();
        test_gaps();
        test_backpressure();
        test_saturation();
        test_midreset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
